// File: rtl/hilo_pkg.sv
// HI/LO multiply unit shared definitions.
//   - DEFAULT_WIDTH : default operand width of HI, LO and the multiplier operands
//   - OP_*          : op field encodings
//   - state_t       : control FSM states
package hilo_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StFin  = 2'b10
   } state_t;

endpackage

// File: rtl/hilo_mult_core.sv
// Iterative radix-2 shift-add multiplier datapath.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture operand magnitudes and sign, clear accumulator and counter
//   is_signed  : treat a/b as two's complement at load
//   a, b       : operands
//   step       : perform one shift-add step
//   last       : the step taken this cycle is the final one
//   product    : sign-corrected 2*WIDTH result (valid once all steps are done)
module hilo_mult_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 step,
   output logic                 last,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               neg_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   // Negation of the most negative value wraps back to itself, which is exactly
   // the correct unsigned magnitude.
   always_comb begin
      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? (-a) : a;
      b_mag = b_neg ? (-b) : b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else if (load) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_mag};
         mplier_q <= b_mag;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= a_neg ^ b_neg;
      end else if (step) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
      end
   end

   assign last    = (cnt_q == CW'(WIDTH - 1));
   assign product = neg_q ? (-acc_q) : acc_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with an iterative multiplier (MULTU/MULT) and direct moves (MTHI/MTLO).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, op      : request strobe and operation (00 MULTU, 01 MULT, 10 MTHI, 11 MTLO)
//   rs_val, rt_val : multiplicand / move source, multiplier
//   rd_req         : downstream read of HI/LO this cycle
//   busy           : multiply in progress (RUN or FIN)
//   done           : one-cycle pulse after HI/LO take a multiply result
//   stall          : rd_req while busy
//   hi, lo         : registered HI and LO
module hilo_unit #(
   parameter int unsigned WIDTH = hilo_pkg::DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   input  logic               rd_req,
   output logic               busy,
   output logic               done,
   output logic               stall,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   import hilo_pkg::*;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               core_load;
   logic               core_step;
   logic               core_last;
   logic [2*WIDTH-1:0] core_product;

   hilo_mult_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (core_load),
      .is_signed (op == OP_MULT),
      .a         (rs_val),
      .b         (rt_val),
      .step      (core_step),
      .last      (core_last),
      .product   (core_product)
   );

   // Requests are only decoded in idle; anything arriving while busy is dropped.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               unique case (op)
                  OP_MULTU, OP_MULT: begin
                     core_load = 1'b1;
                     state_d   = StRun;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         StRun: begin
            core_step = 1'b1;
            if (core_last) begin
               state_d = StFin;
            end
         end
         StFin: begin
            hi_d    = core_product[2*WIDTH-1:WIDTH];
            lo_d    = core_product[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign stall = rd_req & busy;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
